// File: rtl/cru_prog.sv
// Clock and reset unit: synchronised, stretched reset plus a cascade of programmable
// clock-enable dividers with glitch-free run-time divisor updates and phase resync.
module cru_prog #(
    parameter int                         N_STAGES    = 3,
    parameter int                         CNT_W       = 8,
    parameter logic [N_STAGES*CNT_W-1:0]  DIV_INIT    = {8'd30, 8'd50, 8'd5},
    parameter int                         SYNC_STAGES = 2,
    parameter int                         RST_HOLD    = 16,
    parameter int                         SEL_W       = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 reset_out,
    output logic [N_STAGES-1:0]  en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [SEL_W-1:0]     cfg_stage,
    input  logic [CNT_W-1:0]     cfg_div,
    input  logic                 resync,
    output logic [N_STAGES-1:0]  pending
);

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_done;
    logic                   rst_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_done = sync_q[SYNC_STAGES-1];

    // Stretch the synchronised release by RST_HOLD further edges; done is a flop so
    // reset_out is glitch-free.
    generate
        if (RST_HOLD == 0) begin : g_nohold
            assign rst_done = sync_done;
        end else begin : g_hold
            localparam int HW = $clog2(RST_HOLD + 1);
            logic [HW-1:0] hold_cnt;
            logic          done_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hold_cnt <= '0;
                    done_q   <= 1'b0;
                end else if (sync_done && !done_q) begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HW'(RST_HOLD - 1)) begin
                        done_q <= 1'b1;
                    end
                end
            end

            assign rst_done = done_q;
        end
    endgenerate

    assign reset_out = ~rst_done;

    logic [N_STAGES-1:0][CNT_W-1:0] cnt_q;
    logic [N_STAGES-1:0][CNT_W-1:0] div_q;
    logic [N_STAGES-1:0][CNT_W-1:0] shadow_q;
    logic [N_STAGES-1:0]            ein;
    logic [N_STAGES-1:0]            cfg_hit;
    logic                           sel_pend;

    // Enable cascade: each stage counts the wraps of the stage below it.
    always_comb begin
        logic carry;
        en    = '0;
        ein   = '0;
        carry = ~reset_out & ~resync;
        for (int k = 0; k < N_STAGES; k++) begin
            ein[k] = carry;
            en[k]  = carry & (cnt_q[k] == div_q[k] - 1'b1);
            carry  = en[k];
        end
    end

    // Out-of-range stage indices hit nothing, so they are accepted and dropped.
    always_comb begin
        cfg_hit  = '0;
        sel_pend = 1'b0;
        for (int k = 0; k < N_STAGES; k++) begin
            if (int'(cfg_stage) == k) begin
                cfg_hit[k] = 1'b1;
                sel_pend   = pending[k];
            end
        end
        cfg_ready = ~reset_out & ~sel_pend;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            div_q    <= DIV_INIT;
            shadow_q <= '0;
            pending  <= '0;
        end else if (reset_out) begin
            cnt_q   <= '0;
            pending <= '0;
        end else begin
            for (int k = 0; k < N_STAGES; k++) begin
                if (resync) begin
                    cnt_q[k] <= '0;
                    if (pending[k]) begin
                        div_q[k]   <= shadow_q[k];
                        pending[k] <= 1'b0;
                    end
                end else if (ein[k]) begin
                    if (en[k]) begin
                        cnt_q[k] <= '0;
                        // Swap only at the wrap so no period is truncated or stretched.
                        if (pending[k]) begin
                            div_q[k]   <= shadow_q[k];
                            pending[k] <= 1'b0;
                        end
                    end else begin
                        cnt_q[k] <= cnt_q[k] + 1'b1;
                    end
                end
                if (cfg_valid && cfg_ready && cfg_hit[k]) begin
                    shadow_q[k] <= clamp_div(cfg_div);
                    pending[k]  <= 1'b1;
                end
            end
        end
    end

endmodule
